cipher19_core: RTL and testbench

// - Keyed, reversible 19-bit word cipher for the 19-bit CPU datapath; one core does both directions (mode 0 = encrypt, 1 = decrypt).
// - Pipelined: one cipher round per register stage, one word accepted per clock.
// - Sits between the register file / memory interface and any store that must hold obfuscated data.

---
 rtl/cipher19_pkg.sv | 30 +++
 rtl/cipher19_round.sv | 23 ++
 rtl/cipher19_core.sv | 110 +++++++++++
 tb/tb_cipher19_core.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/cipher19_pkg.sv
// Shared types, default constants and rotate helpers for the 19-bit word cipher.
package cipher19_pkg;

  localparam int unsigned W = 19;

  typedef logic [W-1:0] word_t;

  typedef enum logic {
    ENC = 1'b0,
    DEC = 1'b1
  } mode_e;

  localparam word_t       KEY_DEFAULT  = 19'h05555;
  localparam int unsigned ROT_DEFAULT  = 3;
  localparam word_t       ADDC_DEFAULT = 19'h00011;

  // The upper half of the doubled word shifted left is the left rotation.
  function automatic word_t rotl19(input word_t x, input int unsigned r);
    logic [2*W-1:0] d;
    d = {x, x} << r;
    return d[2*W-1:W];
  endfunction

  function automatic word_t rotr19(input word_t x, input int unsigned r);
    logic [2*W-1:0] d;
    d = {x, x} >> r;
    return d[W-1:0];
  endfunction

endpackage

// File: rtl/cipher19_round.sv
// One combinational cipher round; mode selects the forward or the exact inverse transform.
module cipher19_round
  import cipher19_pkg::*;
#(
  parameter int unsigned ROT  = ROT_DEFAULT,
  parameter word_t       ADDC = ADDC_DEFAULT
) (
  input  logic         mode,
  input  logic [W-1:0] key,
  input  logic [W-1:0] data,
  output logic [W-1:0] result
);

  word_t enc_t;
  word_t dec_t;

  always_comb begin
    enc_t  = rotl19(data ^ key, ROT);
    dec_t  = rotr19(data - ADDC, ROT);
    result = (mode == DEC) ? (dec_t ^ key) : (enc_t + ADDC);
  end

endmodule

// File: rtl/cipher19_core.sv
// Pipelined keyed 19-bit word cipher, one round per register stage.
// Optional runtime key register enabled by defining CIPHER_KEY_LOAD_EN.
module cipher19_core
  import cipher19_pkg::*;
#(
  parameter int unsigned ROUNDS = 1,
  parameter word_t       KEY    = KEY_DEFAULT,
  parameter int unsigned ROT    = ROT_DEFAULT,
  parameter word_t       ADDC   = ADDC_DEFAULT
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         in_valid,
  input  logic         in_mode,
  input  logic [W-1:0] in_data,
  output logic         out_valid,
  output logic         out_mode,
  output logic [W-1:0] out_data
`ifdef CIPHER_KEY_LOAD_EN
  ,
  input  logic         key_we,
  input  logic [W-1:0] key_in
`endif
);

  word_t key_cur;

`ifdef CIPHER_KEY_LOAD_EN
  word_t key_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      key_q <= KEY;
    end else if (key_we) begin
      key_q <= key_in;
    end
  end

  assign key_cur = key_q;
`else
  assign key_cur = KEY;
`endif

  for (genvar g = 0; g < ROUNDS; g++) begin : g_stage
    logic  src_valid;
    mode_e src_mode;
    word_t src_data;
    word_t src_key;
    word_t rnd;

    logic  valid_q;
    mode_e mode_q;
    word_t data_q;

    if (g == 0) begin : g_src
      assign src_valid = in_valid;
      assign src_mode  = mode_e'(in_mode);
      assign src_data  = in_data;
      assign src_key   = key_cur;
    end else begin : g_src
      assign src_valid = g_stage[g-1].valid_q;
      assign src_mode  = g_stage[g-1].mode_q;
      assign src_data  = g_stage[g-1].data_q;
      assign src_key   = g_stage[g-1].g_key.key_q;
    end

    cipher19_round #(
      .ROT (ROT),
      .ADDC(ADDC)
    ) u_round (
      .mode  (src_mode),
      .key   (src_key),
      .data  (src_data),
      .result(rnd)
    );

    // Bubbles only advance valid; payload registers keep their last word.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        valid_q <= 1'b0;
        mode_q  <= ENC;
        data_q  <= '0;
      end else begin
        valid_q <= src_valid;
        if (src_valid) begin
          mode_q <= src_mode;
          data_q <= rnd;
        end
      end
    end

    // The last stage has no successor, so its key copy would be dead.
    if (g + 1 < ROUNDS) begin : g_key
      word_t key_q;

      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          key_q <= '0;
        end else if (src_valid) begin
          key_q <= src_key;
        end
      end
    end
  end

  assign out_valid = g_stage[ROUNDS-1].valid_q;
  assign out_mode  = g_stage[ROUNDS-1].mode_q;
  assign out_data  = g_stage[ROUNDS-1].data_q;

endmodule

// File: tb/tb_cipher19_core.sv
// Scoreboard bench: a 1-round and a 5-round core share one randomized input stream.
module tb_cipher19_core;
  import cipher19_pkg::*;

  localparam logic [18:0] KEY0 = 19'h05555;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_mode = 1'b0;
  logic [18:0] in_data = '0;

  logic        o1_valid, o1_mode;
  logic [18:0] o1_data;
  logic        o5_valid, o5_mode;
  logic [18:0] o5_data;

`ifdef CIPHER_KEY_LOAD_EN
  logic        key_we1 = 1'b0;
  logic [18:0] key_in1 = '0;
  logic        key_we5 = 1'b0;
  logic [18:0] key_in5 = '0;
`endif

  logic [18:0] k1 = KEY0;
  int          cyc = 0;
  int          n_checks = 0;
  int          n_pass = 0;

  typedef struct {
    logic [18:0] data;
    logic        mode;
    int          due;
  } exp_t;

  exp_t q1[$];
  exp_t q5[$];

  cipher19_core #(.ROUNDS(1)) u_dut1 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(o1_valid),
    .out_mode (o1_mode),
    .out_data (o1_data)
`ifdef CIPHER_KEY_LOAD_EN
    ,
    .key_we   (key_we1),
    .key_in   (key_in1)
`endif
  );

  cipher19_core #(.ROUNDS(5)) u_dut5 (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_mode  (in_mode),
    .in_data  (in_data),
    .out_valid(o5_valid),
    .out_mode (o5_mode),
    .out_data (o5_data)
`ifdef CIPHER_KEY_LOAD_EN
    ,
    .key_we   (key_we5),
    .key_in   (key_in5)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Reference: n rounds of xor / rotate-by-3 / add-17, written as plain integer arithmetic.
  function automatic logic [18:0] model(input logic [18:0] x, input logic m,
                                        input int n, input logic [18:0] k);
    int unsigned v, t, kk;
    v  = x;
    kk = k;
    for (int i = 0; i < n; i++) begin
      if (m == 1'b0) begin
        t = v ^ kk;
        t = (t * 8) % 524288 + t / 65536;
        v = (t + 17) % 524288;
      end else begin
        t = (v + 524288 - 17) % 524288;
        t = t / 8 + (t % 8) * 65536;
        v = t ^ kk;
      end
    end
    return v[18:0];
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
  endtask

  task automatic drive(input logic m, input logic [18:0] d,
                       input logic fixed_en, input logic [18:0] fixed1);
    exp_t e;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    in_mode  = m;
    in_data  = d;
    e.mode = m;
    e.due  = cyc + 1;
    e.data = fixed_en ? fixed1 : model(d, m, 1, k1);
    q1.push_back(e);
    e.due  = cyc + 5;
    e.data = model(d, m, 5, KEY0);
    q5.push_back(e);
  endtask

  task automatic idle();
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    in_mode  = 1'($urandom);
    in_data  = 19'($urandom);
  endtask

  task automatic chk_zero(input string tag);
    chk({tag, "_o1_valid"}, o1_valid, 0);
    chk({tag, "_o1_mode"},  o1_mode,  0);
    chk({tag, "_o1_data"},  o1_data,  0);
    chk({tag, "_o5_valid"}, o5_valid, 0);
    chk({tag, "_o5_mode"},  o5_mode,  0);
    chk({tag, "_o5_data"},  o5_data,  0);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (o1_valid) begin
        chk("dut1_expected_pending", q1.size() != 0, 1);
        if (q1.size() != 0) begin
          e = q1.pop_front();
          chk("dut1_data", o1_data, e.data);
          chk("dut1_mode", o1_mode, e.mode);
          chk("dut1_latency", cyc, e.due);
        end
      end
      if (o5_valid) begin
        chk("dut5_expected_pending", q5.size() != 0, 1);
        if (q5.size() != 0) begin
          e = q5.pop_front();
          chk("dut5_data", o5_data, e.data);
          chk("dut5_mode", o5_mode, e.mode);
          chk("dut5_latency", cyc, e.due);
        end
      end
    end
  end

  logic [18:0] stream [16] = '{19'd0, 19'd100, 19'd150, 19'd200, 19'd35, 19'd50, 19'd30,
                               19'd607, 19'd342, 19'd440, 19'd5000, 19'd780, 19'd690,
                               19'd245, 19'd780, 19'h7FFFF};

  initial begin
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_zero("reset");
    #1 rst = 1'b0;

    drive(ENC, 19'd0,      1'b1, 19'h2AAB9);
    drive(ENC, 19'd100,    1'b1, 19'h2A999);
    drive(DEC, 19'h2A999,  1'b1, 19'd100);
    drive(ENC, 19'h7FFFF,  1'b1, 19'h55568);
    drive(DEC, 19'h55568,  1'b1, 19'h7FFFF);
    idle();

    for (int i = 0; i < 16; i++) drive(ENC, stream[i], 1'b0, '0);
    for (int i = 0; i < 16; i++) drive(DEC, model(stream[i], ENC, 1, k1), 1'b1, stream[i]);
    idle();

    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 3) == 0) idle();
      else drive(1'($urandom), 19'($urandom), 1'b0, '0);
    end

    for (int i = 0; i < 4; i++) drive(ENC, 19'($urandom), 1'b0, '0);
    #2;
    rst      = 1'b1;
    in_valid = 1'b0;
    #1;
    chk_zero("midreset");
    q1.delete();
    q5.delete();
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("post_reset_o1_valid", o1_valid, 0);
      chk("post_reset_o5_valid", o5_valid, 0);
    end

    drive(DEC, 19'd0, 1'b0, '0);
    drive(ENC, 19'h7FFFF, 1'b0, '0);
    idle();

`ifdef CIPHER_KEY_LOAD_EN
    drive(ENC, 19'd0, 1'b1, 19'h2AAB9);
    key_we1 = 1'b1;
    key_in1 = '0;
    k1      = '0;
    drive(ENC, 19'd0, 1'b1, 19'h00011);
    key_we1 = 1'b0;
    drive(DEC, 19'h00011, 1'b1, 19'd0);
    idle();
`endif

    for (int i = 0; i < 20 && (q1.size() != 0 || q5.size() != 0); i++) @(posedge clk);
    @(posedge clk);
    #1;
    chk("drain_q1", q1.size(), 0);
    chk("drain_q5", q5.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
